// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode/ALU-op constants and the decoded control
//                bundle used by the ID/EX stage of the 5-stage MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // ALU operation classes handed to EX
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Which instruction field names the destination register
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2
  } dst_sel_t;

  // Decoded control bundle; uses_rt marks instructions that read rt as a
  // source, which matters for load-use detection.
  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic [1:0] aluop;
    dst_sel_t   dst_sel;
    logic       uses_rt;
  } ctrl_t;

  // All-inactive control bundle
  function automatic ctrl_t ctrl_none();
    ctrl_t c;
    c = '0;
    c.dst_sel = DST_NONE;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ctrl_decode.sv
// ============================================================================
//  Module      : id_ctrl_decode
//  Description : Combinational opcode decoder producing the control bundle
//                and an illegal-opcode flag for the ID stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Opcode lookup; unknown opcodes yield an all-zero bundle plus illegal
  always_comb begin
    ctrl    = ctrl_none();
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_FUNCT;
        ctrl.dst_sel  = DST_RD;
        ctrl.uses_rt  = 1'b1;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.dst_sel  = DST_RT;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.uses_rt  = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.aluop    = ALU_SUB;
        ctrl.uses_rt  = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.dst_sel  = DST_RT;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe.sv
// ============================================================================
//  Module      : id_ex_pipe
//  Description : ID/EX pipeline stage: decode, WB->ID operand bypass,
//                load-use stall detection and the EX-stage register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic              ex_illegal
);

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] dst;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] a_byp;
  logic [DATA_W-1:0] b_byp;
  ctrl_t             ctrl;
  logic              illegal;
  logic              bubble;

  assign rs  = id_instr[25:21];
  assign rt  = id_instr[20:16];
  assign rd  = id_instr[15:11];
  assign imm = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

  id_ctrl_decode u_decode (
    .opcode  (id_instr[31:26]),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  // Destination register selection
  always_comb begin
    case (ctrl.dst_sel)
      DST_RD:  dst = rd;
      DST_RT:  dst = rt;
      default: dst = '0;
    endcase
  end

  // Register file does not return data being written this cycle, so a
  // same-cycle WB write to a source register is bypassed here.
  always_comb begin
    a_byp = A;
    b_byp = B;
    if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) a_byp = wb_data;
    if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt)) b_byp = wb_data;
  end

  // Load-use hazard: the load in EX feeds a source of the ID instruction.
  // A flush squashes ID, so it never stalls.
  always_comb begin
    stall = id_valid && ex_valid && ex_memread && (ex_dst != '0) &&
            ((ex_dst == rs) || ((ex_dst == rt) && ctrl.uses_rt)) &&
            !ex_flush;
  end

  // Flush, stall, empty ID and illegal opcodes all insert a bubble
  assign bubble = ex_flush || stall || !id_valid || illegal;

  // EX-stage pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      ex_pc4      <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_illegal  <= 1'b0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      ex_pc4      <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_illegal  <= id_valid && illegal && !ex_flush && !stall;
    end else begin
      ex_valid    <= 1'b1;
      ex_a        <= a_byp;
      ex_b        <= b_byp;
      ex_imm      <= imm;
      ex_rs       <= rs;
      ex_rt       <= rt;
      ex_dst      <= dst;
      ex_pc4      <= id_pc4;
      ex_regwrite <= ctrl.regwrite && (dst != '0);
      ex_memread  <= ctrl.memread;
      ex_memwrite <= ctrl.memwrite;
      ex_memtoreg <= ctrl.memtoreg;
      ex_alusrc   <= ctrl.alusrc;
      ex_branch   <= ctrl.branch;
      ex_aluop    <= ctrl.aluop;
      ex_illegal  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
// ============================================================================
//  Module      : tb_id_ex_pipe
//  Description : Self-checking bench for id_ex_pipe: directed test-plan
//                steps followed by randomized instruction streams, checked
//                against a table-driven reference of the EX slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [31:0] A;
  logic [31:0] B;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic        ex_alusrc, ex_branch, ex_illegal;
  logic [1:0]  ex_aluop;

  id_ex_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc4(id_pc4), .A(A), .B(B), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush), .stall(stall),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_pc4(ex_pc4),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Expected content of the EX slot
  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rs, rt, dst;
    logic        regwrite, memread, memwrite, memtoreg, alusrc, branch;
    logic [1:0]  aluop;
  } ex_t;

  ex_t exp_ex;
  int  compared = 0;
  int  failed   = 0;
  logic obs_stall;
  logic exp_stall_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_ex(input string tag);
    check({tag, ".valid"},    64'(ex_valid),    64'(exp_ex.valid));
    check({tag, ".illegal"},  64'(ex_illegal),  64'(exp_ex.illegal));
    check({tag, ".a"},        64'(ex_a),        64'(exp_ex.a));
    check({tag, ".b"},        64'(ex_b),        64'(exp_ex.b));
    check({tag, ".imm"},      64'(ex_imm),      64'(exp_ex.imm));
    check({tag, ".pc4"},      64'(ex_pc4),      64'(exp_ex.pc4));
    check({tag, ".rs"},       64'(ex_rs),       64'(exp_ex.rs));
    check({tag, ".rt"},       64'(ex_rt),       64'(exp_ex.rt));
    check({tag, ".dst"},      64'(ex_dst),      64'(exp_ex.dst));
    check({tag, ".regwrite"}, 64'(ex_regwrite), 64'(exp_ex.regwrite));
    check({tag, ".memread"},  64'(ex_memread),  64'(exp_ex.memread));
    check({tag, ".memwrite"}, 64'(ex_memwrite), 64'(exp_ex.memwrite));
    check({tag, ".memtoreg"}, 64'(ex_memtoreg), 64'(exp_ex.memtoreg));
    check({tag, ".alusrc"},   64'(ex_alusrc),   64'(exp_ex.alusrc));
    check({tag, ".branch"},   64'(ex_branch),   64'(exp_ex.branch));
    check({tag, ".aluop"},    64'(ex_aluop),    64'(exp_ex.aluop));
  endtask

  // Does the ID instruction need to wait for the load currently in EX?
  function automatic logic model_stall(input ex_t cur, input logic [31:0] ins,
                                       input logic v, input logic fl);
    logic [5:0] op;
    logic       reads_rt;
    op       = ins[31:26];
    reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    if (!v || fl || !cur.valid || !cur.memread || cur.dst == 5'd0) return 1'b0;
    return (cur.dst == ins[25:21]) || (reads_rt && cur.dst == ins[20:16]);
  endfunction

  // What EX holds after the edge, from the instruction-set table
  function automatic ex_t model_next(input logic [31:0] ins, input logic v,
                                     input logic [31:0] pc4, a_in, b_in,
                                     input logic wrw, input logic [4:0] wrd,
                                     input logic [31:0] wd, input logic fl,
                                     input logic stl);
    ex_t n;
    logic [4:0] dreg;
    logic       rw;
    n = '0;
    if (fl || stl || !v) return n;
    rw = 1'b0;
    dreg = 5'd0;
    case (ins[31:26])
      6'h00: begin rw = 1; n.aluop = 2'b10; dreg = ins[15:11]; end
      6'h23: begin rw = 1; n.memread = 1; n.memtoreg = 1; n.alusrc = 1; dreg = ins[20:16]; end
      6'h2B: begin n.memwrite = 1; n.alusrc = 1; end
      6'h04: begin n.branch = 1; n.aluop = 2'b01; end
      6'h08: begin rw = 1; n.alusrc = 1; dreg = ins[20:16]; end
      default: begin n.illegal = 1; return n; end
    endcase
    n.valid    = 1;
    n.dst      = dreg;
    n.regwrite = rw && (dreg != 0);
    n.rs       = ins[25:21];
    n.rt       = ins[20:16];
    n.imm      = {{16{ins[15]}}, ins[15:0]};
    n.pc4      = pc4;
    n.a        = (wrw && wrd != 0 && wrd == ins[25:21]) ? wd : a_in;
    n.b        = (wrw && wrd != 0 && wrd == ins[20:16]) ? wd : b_in;
    return n;
  endfunction

  // One ID presentation: drive, check the combinational stall, clock, check EX
  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic [31:0] pc4, a_in, b_in, input logic wrw,
                      input logic [4:0] wrd, input logic [31:0] wd, input logic fl);
    @(negedge clk);
    id_instr = ins; id_valid = v; id_pc4 = pc4; A = a_in; B = b_in;
    wb_regwrite = wrw; wb_rd = wrd; wb_data = wd; ex_flush = fl;
    #1;
    exp_stall_v = model_stall(exp_ex, ins, v, fl);
    obs_stall = stall;
    check({tag, ".stall"}, 64'(stall), 64'(exp_stall_v));
    @(posedge clk);
    #1;
    exp_ex = model_next(ins, v, pc4, a_in, b_in, wrw, wrd, wd, fl, exp_stall_v);
    check_ex(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    case ($urandom_range(0, 6))
      0:       return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1, 2:    return {6'h23, rs, rt, im};
      3:       return {6'h2B, rs, rt, im};
      4:       return {6'h04, rs, rt, im};
      5:       return {6'h08, rs, rt, im};
      default: return {($urandom_range(0, 1) == 0) ? 6'h3F : 6'h02, rs, rt, im};
    endcase
  endfunction

  localparam logic [31:0] I_ADDI_NEG4 = 32'h2005FFFC;
  localparam logic [31:0] I_LW_2_1    = 32'h8C220000;
  localparam logic [31:0] I_ADD_3_2_4 = 32'h00441820;
  localparam logic [31:0] I_SW_2_6    = 32'hACC20000;
  localparam logic [31:0] I_ADDI_7_2  = 32'h20470001;
  localparam logic [31:0] I_LW_0_1    = 32'h8C200000;
  localparam logic [31:0] I_ADD_3_0_4 = 32'h00041820;
  localparam logic [31:0] I_ADD_3_7_8 = 32'h00E81820;
  localparam logic [31:0] I_ILLEGAL   = 32'hFC000000;

  initial begin
    logic [31:0] ins, pc;
    logic        v;
    reset = 1'b1; id_valid = 0; id_instr = 0; id_pc4 = 0; A = 0; B = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0; ex_flush = 0;
    exp_ex = '0;
    repeat (2) @(posedge clk);
    #1;
    check_ex("reset");
    check("reset.stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // addi $5,$0,-4
    step("addi", I_ADDI_NEG4, 1, 32'h104, 32'h1, 32'h2, 0, 0, 0, 0);
    check("addi.imm_const", 64'(ex_imm), 64'hFFFF_FFFC);
    check("addi.dst_const", 64'(ex_dst), 64'd5);
    check("addi.rw_const", 64'(ex_regwrite), 64'd1);
    check("addi.alusrc_const", 64'(ex_alusrc), 64'd1);
    check("addi.aluop_const", 64'(ex_aluop), 64'd0);

    // lw $2 then add/sw/addi consumers: one stall cycle each
    step("lu_lw1", I_LW_2_1, 1, 32'h200, 32'h10, 32'h20, 0, 0, 0, 0);
    step("lu_add_s", I_ADD_3_2_4, 1, 32'h204, 32'h30, 32'h40, 0, 0, 0, 0);
    check("lu_add.stall_const", 64'(obs_stall), 64'd1);
    check("lu_add.bubble_const", 64'(ex_valid), 64'd0);
    step("lu_add", I_ADD_3_2_4, 1, 32'h204, 32'h30, 32'h40, 0, 0, 0, 0);
    check("lu_add.nostall_const", 64'(obs_stall), 64'd0);
    check("lu_add.rs_const", 64'(ex_rs), 64'd2);
    step("lu_lw2", I_LW_2_1, 1, 32'h208, 32'h10, 32'h20, 0, 0, 0, 0);
    step("lu_sw_s", I_SW_2_6, 1, 32'h20C, 32'h5, 32'h6, 0, 0, 0, 0);
    check("lu_sw.stall_const", 64'(obs_stall), 64'd1);
    step("lu_sw", I_SW_2_6, 1, 32'h20C, 32'h5, 32'h6, 0, 0, 0, 0);
    step("lu_lw3", I_LW_2_1, 1, 32'h210, 32'h10, 32'h20, 0, 0, 0, 0);
    step("lu_addi_s", I_ADDI_7_2, 1, 32'h214, 32'h7, 32'h8, 0, 0, 0, 0);
    check("lu_addi.stall_const", 64'(obs_stall), 64'd1);
    step("lu_addi", I_ADDI_7_2, 1, 32'h214, 32'h7, 32'h8, 0, 0, 0, 0);

    // load to $0 never stalls
    step("lw0", I_LW_0_1, 1, 32'h300, 32'h1, 32'h2, 0, 0, 0, 0);
    step("add0", I_ADD_3_0_4, 1, 32'h304, 32'h1, 32'h2, 0, 0, 0, 0);
    check("add0.stall_const", 64'(obs_stall), 64'd0);

    // WB bypass into A, and no bypass for $0
    step("byp", I_ADD_3_7_8, 1, 32'h400, 32'h11, 32'h22, 1, 5'd7, 32'hABCD, 0);
    check("byp.a_const", 64'(ex_a), 64'hABCD);
    step("byp0", I_ADD_3_7_8, 1, 32'h404, 32'h11, 32'h22, 1, 5'd0, 32'hABCD, 0);
    check("byp0.a_const", 64'(ex_a), 64'h11);

    // flush together with a load-use pair
    step("fl_lw", I_LW_2_1, 1, 32'h500, 32'h1, 32'h2, 0, 0, 0, 0);
    step("fl_add", I_ADD_3_2_4, 1, 32'h504, 32'h1, 32'h2, 0, 0, 0, 1);
    check("fl.stall_const", 64'(obs_stall), 64'd0);
    check("fl.bubble_const", 64'(ex_valid), 64'd0);

    // illegal opcode: one-cycle pulse
    step("ill", I_ILLEGAL, 1, 32'h600, 32'h1, 32'h2, 0, 0, 0, 0);
    check("ill.pulse_const", 64'(ex_illegal), 64'd1);
    step("ill_after", I_ADDI_NEG4, 1, 32'h604, 32'h1, 32'h2, 0, 0, 0, 0);
    check("ill.clear_const", 64'(ex_illegal), 64'd0);

    // randomized stream; a stalled instruction is re-presented
    ins = rand_instr(); v = 1'b1; pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step("rnd", ins, v, pc, $urandom, $urandom, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0));
      if (!exp_stall_v) begin
        ins = rand_instr();
        v   = ($urandom_range(0, 9) != 0);
        pc  = pc + 4;
      end
    end

    // asynchronous reset in the middle of a stall
    step("rst_lw", I_LW_2_1, 1, 32'h700, 32'h1, 32'h2, 0, 0, 0, 0);
    @(negedge clk);
    id_instr = I_ADD_3_2_4; id_valid = 1; ex_flush = 0; wb_regwrite = 0;
    #1;
    check("rst.pre_stall", 64'(stall), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_ex = '0;
    check_ex("rst_async");
    check("rst_async.stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Sits directly downstream of the register-file read stage.
- Decodes the ID-stage instruction into control bits and bypasses same-cycle WB writes into the A/B operands.
- Detects load-use hazards, then registers operands, immediate, register fields and control into the EX stage. Supports stall and flush.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction in ID
- id_pc4  in  DATA_W  PC+4 of that instruction
- A  in  DATA_W  register-file read of rs
- B  in  DATA_W  register-file read of rt
- wb_regwrite  in  1  WB stage writing the register file this cycle
- wb_rd  in  REG_AW  WB destination register
- wb_data  in  DATA_W  WB write data
- ex_flush  in  1  taken branch resolved in EX; squash ID
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_a, ex_b  out  DATA_W  registered operands
- ex_imm  out  DATA_W  sign-extended imm16
- ex_rs, ex_rt  out  REG_AW  source indices, for EX forwarding
- ex_dst  out  REG_AW  destination register (0 if none)
- ex_pc4  out  DATA_W  registered PC+4
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  out  1 each  control
- ex_aluop  out  2  00 add, 01 sub, 10 funct-decoded
- ex_illegal  out  1  unknown opcode captured (1-cycle pulse)

Behaviour:
- Reset (async, immediate): all ex_* outputs 0, ex_valid 0. stall becomes 0 through its gating by ex_valid.
- Decode, by opcode:
  - 0x00 R-type: regwrite, aluop 10, dst = rd.
  - 0x23 lw: regwrite, memread, memtoreg, alusrc, aluop 00, dst = rt.
  - 0x2B sw: memwrite, alusrc, aluop 00, dst = 0.
  - 0x04 beq: branch, aluop 01, dst = 0.
  - 0x08 addi: regwrite, alusrc, aluop 00, dst = rt.
  - Any other opcode: all controls 0, ex_valid 0, ex_illegal 1 for one cycle.
  - dst = 0 forces regwrite 0.
- Imm: ex_imm = {16{instr[15]}, instr[15:0]}.
- WB bypass:
  - A' = wb_data if wb_regwrite && wb_rd != 0 && wb_rd == rs; else A.
  - B' uses the same rule with rt.
  - Covers the register file not returning read data on cycles it is being written.
- Load-use hazard: stall = id_valid && ex_valid && ex_memread && ex_dst != 0 && (ex_dst == rs || (ex_dst == rt && opcode in {R, sw, beq})) && !ex_flush.
- Per-edge update, in priority order:
  1. ex_flush = 1: EX loads a bubble (ex_valid 0, all controls 0, data fields 0).
  2. Else stall = 1: EX loads a bubble. The ID instruction is held upstream and re-presented next cycle. Stall lasts exactly 1 cycle per load-use pair.
  3. Else: EX loads the decoded ID instruction; ex_valid = id_valid && legal opcode.
- Simultaneous flush and stall: flush wins, stall driven 0.
- Latency: 1 cycle ID→EX, 2 cycles on load-use.
- Reset asserted mid-stall: EX clears immediately; stall drops the same instant.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - aluop constants ALU_ADD, ALU_SUB, ALU_FUNCT
  - a control-bundle struct typedef
- One sub-module, id_ctrl_decode: combinational opcode → control bundle plus illegal flag.
- Hazard, bypass and the pipeline register stay in id_ex_pipe.

Test Plan:
- Reset pulsed mid-run with ex_valid 1 → all ex_* 0 asynchronously, before the next edge; stall 0.
- addi $5,$0,-4 (0x2005FFFC) → next edge: ex_imm = 0xFFFFFFFC, ex_dst = 5, regwrite 1, alusrc 1, aluop 00.
- lw $2,0($1) then add $3,$2,$4 → stall 1 for exactly 1 cycle, EX bubble, then the add enters EX with ex_rs = 2. Repeat with sw $2,0($6) as the consumer → stall 1 (rt use). Repeat with addi $7,$2,1 → stall 1 (rs use).
- lw $0,0($1) then add $3,$0,$4 → no stall.
- ID add $3,$7,$8 with A = 0x11, wb_regwrite 1, wb_rd 7, wb_data 0xABCD → ex_a = 0xABCD. With wb_rd = 0 → ex_a = 0x11.
- Load-use pair and ex_flush 1 in the same cycle → stall 0, EX bubble.
- Opcode 0x3F → ex_illegal pulses 1 cycle, ex_valid 0, all controls 0.
